// File: rtl/tree_pkg.sv
// Shared constants and helpers for the decision-tree level pipeline.
package tree_pkg;

    localparam logic CMP_LT = 1'b0;
    localparam logic CMP_LE = 1'b1;

    // Heap index of the first node on level l.
    function automatic int level_base(input int l);
        return (1 << l) - 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tree_thr_ram.sv
// Per-level threshold table: synchronous read with enable, write-first.
module tree_thr_ram
    import tree_pkg::*;
#(
    parameter int KEY_W = 16,
    parameter int LEVEL = 0,
    parameter logic [KEY_W-1:0] INIT_THR = 16'h8000,
    parameter int ADDR_W = (LEVEL < 1) ? 1 : clog2(1 << LEVEL)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [KEY_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [KEY_W-1:0]  rdata
);

    localparam int DEPTH = 1 << LEVEL;

    logic wr_ok;
    logic bypass;

    // At LEVEL 0 the address port is wider than the table; drop those writes.
    assign wr_ok  = we && (int'(waddr) < DEPTH);
    assign bypass = wr_ok && (waddr == raddr);

    if (LEVEL <= 10) begin : g_dist
        (* ram_style = "distributed" *)
        logic [KEY_W-1:0] mem [2**ADDR_W] = '{default: INIT_THR};

        always_ff @(posedge clk) begin
            if (wr_ok) mem[waddr] <= wdata;
            if (re) rdata <= bypass ? wdata : mem[raddr];
        end
    end else begin : g_block
        (* ram_style = "block" *)
        logic [KEY_W-1:0] mem [2**ADDR_W] = '{default: INIT_THR};

        always_ff @(posedge clk) begin
            if (wr_ok) mem[waddr] <= wdata;
            if (re) rdata <= bypass ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/tree_search_level.sv
// One level of the pipelined decision tree: threshold lookup then child select.
module tree_search_level
    import tree_pkg::*;
#(
    parameter int KEY_W = 16,
    parameter int LEVEL = 0,
    parameter int IDX_IN_W = LEVEL + 1,
    parameter int IDX_OUT_W = LEVEL + 2,
    parameter int CMP_LE = 0,
    parameter logic [KEY_W-1:0] INIT_THR = 16'h8000,
    parameter int ERR_CNT_W = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [KEY_W-1:0]                    key_in,
    input  logic [IDX_IN_W-1:0]                 index_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [KEY_W-1:0]                    key_out,
    output logic [IDX_OUT_W-1:0]                index_out,
    output logic                                err_out,
    input  logic                                cfg_we,
    input  logic [((LEVEL < 1) ? 1 : LEVEL)-1:0] cfg_addr,
    input  logic [KEY_W-1:0]                    cfg_data,
    output logic [ERR_CNT_W-1:0]                err_cnt
);

    localparam int ADDR_W = (LEVEL < 1) ? 1 : LEVEL;
    localparam int BASE = level_base(LEVEL);
    localparam int NODES = 1 << LEVEL;
    localparam logic MODE = (CMP_LE != 0) ? tree_pkg::CMP_LE : tree_pkg::CMP_LT;

    logic                 adv;
    logic [IDX_OUT_W-1:0] idx_ext;
    logic [IDX_OUT_W-1:0] local_idx;
    logic                 range_err;

    logic                 a_valid;
    logic [KEY_W-1:0]     a_key;
    logic [IDX_OUT_W-1:0] a_idx;
    logic                 a_err;
    logic [KEY_W-1:0]     a_thr;

    logic                 go_left;
    logic [IDX_OUT_W-1:0] child;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign idx_ext   = IDX_OUT_W'(index_in);
    assign local_idx = idx_ext - IDX_OUT_W'(BASE);
    assign range_err = (idx_ext < IDX_OUT_W'(BASE))
                    || (local_idx >= IDX_OUT_W'(NODES));

    tree_thr_ram #(
        .KEY_W    (KEY_W),
        .LEVEL    (LEVEL),
        .INIT_THR (INIT_THR),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .re    (adv),
        .raddr (local_idx[ADDR_W-1:0]),
        .rdata (a_thr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_key   <= '0;
            a_idx   <= '0;
            a_err   <= 1'b0;
        end else if (adv) begin
            a_valid <= in_valid;
            a_key   <= key_in;
            a_idx   <= idx_ext;
            a_err   <= range_err;
        end
    end

    assign go_left = (MODE == tree_pkg::CMP_LE) ? (a_key <= a_thr)
                                                : (a_key < a_thr);
    assign child = (a_idx << 1)
                 + (go_left ? IDX_OUT_W'(1) : IDX_OUT_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            key_out   <= '0;
            index_out <= '0;
            err_out   <= 1'b0;
        end else if (adv) begin
            out_valid <= a_valid;
            key_out   <= a_key;
            index_out <= a_err ? '0 : child;
            err_out   <= a_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err_out && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule
